// File: rtl/conv_pkg.sv
// Shared widths, kernel rows and FSM states for the 3x3 convolution window feeder.
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int DATA_W = 24;

    // Kernel rows, byte order matches the data bus: [23:16]=x-2, [15:8]=x-1, [7:0]=x
    localparam logic [DATA_W-1:0] KROW0 = 24'hFFFFFF;
    localparam logic [DATA_W-1:0] KROW1 = 24'hFF08FF;
    localparam logic [DATA_W-1:0] KROW2 = 24'hFFFFFF;

    typedef enum logic [2:0] {
        ACCEPT,
        EMIT0,
        EMIT1,
        EMIT2,
        DONE
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixels: combinational read, synchronous single-port write.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Store the incoming pixel at its column; contents need no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream in, 3x3 windows out to the MAC as three row beats with kernel rows.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] weight,
    output logic              mac_valid,
    output logic              mac_start,
    output logic              frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [DATA_W-1:0] top_row;
    logic [DATA_W-1:0] mid_row;
    logic [DATA_W-1:0] bot_row;
    logic              last_win;

    logic [PIX_W-1:0]  lb1_q;
    logic [PIX_W-1:0]  lb2_q;
    logic              take;
    logic              win;
    logic [DATA_W-1:0] top_next;
    logic [DATA_W-1:0] mid_next;
    logic [DATA_W-1:0] bot_next;

    assign take = (state == ACCEPT) && pix_valid && pix_ready;
    assign win  = (x >= XW'(2)) && (y >= YW'(2));

    assign top_next = {top_row[DATA_W-PIX_W-1:0], lb2_q};
    assign mid_next = {mid_row[DATA_W-PIX_W-1:0], lb1_q};
    assign bot_next = {bot_row[DATA_W-PIX_W-1:0], pix_in};

    // lb1 holds row y-1, lb2 holds row y-2; on a take each line ages by one row
    line_buffer #(.DEPTH(IMG_W), .AW(XW)) u_lb1 (
        .clk   (clk),
        .we    (take),
        .waddr (x),
        .wdata (pix_in),
        .raddr (x),
        .rdata (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(XW)) u_lb2 (
        .clk   (clk),
        .we    (take),
        .waddr (x),
        .wdata (lb1_q),
        .raddr (x),
        .rdata (lb2_q)
    );

    // Window FSM: outputs are registered, so each transition loads the beat of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCEPT;
            x          <= '0;
            y          <= '0;
            top_row    <= '0;
            mid_row    <= '0;
            bot_row    <= '0;
            last_win   <= 1'b0;
            pix_ready  <= 1'b0;
            data       <= '0;
            weight     <= '0;
            mac_valid  <= 1'b0;
            mac_start  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    pix_ready  <= 1'b1;
                    mac_valid  <= 1'b0;
                    mac_start  <= 1'b0;
                    data       <= '0;
                    weight     <= '0;
                    frame_done <= 1'b0;
                    if (take) begin
                        top_row <= top_next;
                        mid_row <= mid_next;
                        bot_row <= bot_next;
                        if (x == XLAST) begin
                            x <= '0;
                            y <= (y == YLAST) ? '0 : y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        if (win) begin
                            state     <= EMIT0;
                            pix_ready <= 1'b0;
                            mac_valid <= 1'b1;
                            mac_start <= 1'b1;
                            data      <= top_next;
                            weight    <= KROW0;
                            last_win  <= (x == XLAST) && (y == YLAST);
                        end
                    end
                end
                EMIT0: begin
                    state     <= EMIT1;
                    mac_start <= 1'b0;
                    data      <= mid_row;
                    weight    <= KROW1;
                end
                EMIT1: begin
                    state  <= EMIT2;
                    data   <= bot_row;
                    weight <= KROW2;
                end
                EMIT2: begin
                    mac_valid <= 1'b0;
                    data      <= '0;
                    weight    <= '0;
                    if (last_win) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state     <= ACCEPT;
                        pix_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= ACCEPT;
                    frame_done <= 1'b0;
                    pix_ready  <= 1'b1;
                    last_win   <= 1'b0;
                    x          <= '0;
                    y          <= '0;
                end
                default: begin
                    state     <= ACCEPT;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
